mc_datapath_regs: RTL
=====================

Name: mc_datapath_regs

Overview:
- Architectural and inter-stage register bank of the multicycle MIPS datapath.
- Sits directly downstream of the multicycle control FSM and consumes its PCWrite, PCWriteCond, IRWrite and PCSource outputs.
- Holds PC, IR, MDR, A, B and ALUOut.
- Computes the next-PC select, decodes the IR fields and imposes a sticky HALT freeze.
- Keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode that freezes fetch.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC update (from control).
- PCWriteCond  in  1  PC update qualified by zero (branch).
- IRWrite  in  1  load IR from memory read data.
- PCSource  in  2  next-PC select.
- zero  in  1  ALU zero flag, same cycle.
- alu_result  in  32  combinational ALU output.
- mem_rdata  in  32  memory read data.
- rf_rdata1  in  32  register-file port 1 (rs).
- rf_rdata2  in  32  register-file port 2 (rt).
- pc  out  32  program counter register.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- reg_a  out  32  A latch.
- reg_b  out  32  B latch.
- alu_out  out  32  ALUOut latch.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- funct  out  6  ir[5:0].
- imm_sext  out  32  sign-extended ir[15:0].
- jump_target  out  32  {pc[31:28], ir[25:0], 2'b00}.
- pc_en  out  1  combinational PC write enable.
- halted  out  1  sticky halt flag.
- instr_count  out  32  count of instruction fetches.

Behaviour:
- Reset, asynchronous and active-high, has priority over all else:
  - pc = RESET_PC.
  - ir, mdr, reg_a, reg_b, alu_out = 0.
  - halted = 0; instr_count = 0.
  - Reset asserted mid-instruction discards all in-flight latches.
- Free-running latches, updated every edge with no enable:
  - mdr <= mem_rdata
  - reg_a <= rf_rdata1
  - reg_b <= rf_rdata2
  - alu_out <= alu_result
  - Latency is 1 cycle. These keep updating while halted.
- pc_en = !halted & (PCWrite | (PCWriteCond & zero)).
  - PCWrite and PCWriteCond together gives pc_en = 1 (OR), so PCWrite dominates.
- Next-PC select when pc_en:
  - 00: alu_result (PC+4).
  - 01: alu_out (branch target).
  - 10: jump_target.
  - 11: hold the current pc.
  - pc holds whenever pc_en = 0.
- IR load: ir <= mem_rdata when IRWrite & !halted; otherwise ir holds.
- Halt:
  - On an edge where IRWrite & !halted & mem_rdata[31:26]==HALT_OPCODE, set halted <= 1 in the same edge that loads ir.
  - The PC update in that edge still occurs, so pc ends at HALT address+4.
  - From the next cycle on, pc and ir are frozen and instr_count stops.
  - Only rst clears halted.
- instr_count:
  - Increments by 1 on every edge with IRWrite & !halted; the HALT fetch itself counts.
  - Saturates at 32'hFFFFFFFF and does not wrap.
- Decode outputs (opcode, rs, rt, rd, funct, imm_sext, jump_target) are combinational from the ir and pc registers only, never from mem_rdata.
  - jump_target uses the current pc register, which is already PC+4 after the fetch state.
- No internal FSM sequencing. The sequencing states are fetch/decode/execute/mem/writeback, owned by control. This block has a single state bit: halted (RUN → HALTED, sticky).

Test Plan:
- Reset with RESET_PC=0, then fetch: IRWrite=1, PCWrite=1, PCSource=00, alu_result=4, mem_rdata=32'h8C220004 -> next cycle pc=4, ir=8C220004, opcode=100011, rs=1, rt=2, imm_sext=4, instr_count=1.
- Branch taken vs not: PCWriteCond=1, PCSource=01, alu_out=32'h40; zero=1 -> pc=40. Repeat with zero=0 -> pc unchanged and pc_en=0.
- Jump: pc=32'h10000008, ir=08000010, PCWrite=1, PCSource=10 -> jump_target=10000040, and pc=10000040 after the edge.
- HALT: fetch mem_rdata=FC000000 at pc=8 (alu_result=C) -> pc=C, halted=1. Further IRWrite/PCWrite pulses over 10 cycles leave pc=C, ir=FC000000 and instr_count unchanged, while mdr still tracks mem_rdata.
- Asynchronous reset mid-operation: assert rst between clock edges while halted with pc=C -> pc=0, halted=0, instr_count=0 immediately without waiting for a clock edge. After release, the next fetch proceeds normally.
- Saturation: force instr_count to FFFFFFFE, then 3 fetches -> count reads FFFFFFFF and stays there.

Source files
------------

// File: rtl/mc_datapath_regs_if.sv
// ============================================================================
// Module      : mc_datapath_regs_if
// Description : Bus bundle between the multicycle control/datapath logic and
//               the datapath register bank. The master drives the control
//               strobes and data operands. The slave (the register bank)
//               returns the architectural and inter-stage registers, the
//               decoded IR fields and its status.
//   master -> slave : PCWrite, PCWriteCond, IRWrite, PCSource[1:0], zero,
//                     alu_result, mem_rdata, rf_rdata1, rf_rdata2
//   slave -> master : pc, ir, mdr, reg_a, reg_b, alu_out, opcode, rs, rt, rd,
//                     funct, imm_sext, jump_target, pc_en, halted,
//                     instr_count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_datapath_regs_if;
  // control / operand inputs to the register bank
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IRWrite;
  logic [1:0]  PCSource;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  // register bank outputs
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [31:0] alu_out;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] jump_target;
  logic        pc_en;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    output PCWrite, PCWriteCond, IRWrite, PCSource, zero,
           alu_result, mem_rdata, rf_rdata1, rf_rdata2,
    input  pc, ir, mdr, reg_a, reg_b, alu_out, opcode, rs, rt, rd,
           funct, imm_sext, jump_target, pc_en, halted, instr_count
  );

  modport slave (
    input  PCWrite, PCWriteCond, IRWrite, PCSource, zero,
           alu_result, mem_rdata, rf_rdata1, rf_rdata2,
    output pc, ir, mdr, reg_a, reg_b, alu_out, opcode, rs, rt, rd,
           funct, imm_sext, jump_target, pc_en, halted, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/mc_datapath_regs.sv
// ============================================================================
// Module      : mc_datapath_regs
// Description : Architectural and inter-stage register bank of the multicycle
//               MIPS datapath. It holds PC, IR, MDR, A, B and ALUOut, and it
//               selects the next PC. It decodes the IR fields, applies a
//               sticky HALT freeze and counts retired fetches.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mc_datapath_regs_if.slave (control strobes and operands in;
//          registers, decode fields, pc_en, halted, instr_count out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mc_datapath_regs_if.slave     bus
);

  // The only sequencing state owned here: RUN until a HALT is fetched.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

  state_t      state_q;
  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;
  logic [31:0] count_q;
  logic [31:0] instr_count_q;

  logic        halted_w;
  logic        pc_en_w;
  logic        fetch_w;
  logic [31:0] jump_target_w;

  assign halted_w      = (state_q == ST_HALTED);
  assign pc_en_w       = !halted_w & (bus.PCWrite | (bus.PCWriteCond & bus.zero));
  assign fetch_w       = bus.IRWrite & !halted_w;
  // Uses the PC register, which is already PC+4 after the fetch state.
  assign jump_target_w = {pc_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (pc_en_w) begin
      unique case (bus.PCSource)
        2'b00:   pc_d = bus.alu_result;
        2'b01:   pc_d = alu_out_q;
        2'b10:   pc_d = jump_target_w;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      mdr_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      alu_out_q     <= '0;
      instr_count_q <= '0;
    end else begin
      // Inter-stage latches run freely, even while halted.
      mdr_q     <= bus.mem_rdata;
      a_q       <= bus.rf_rdata1;
      b_q       <= bus.rf_rdata2;
      alu_out_q <= bus.alu_result;
      pc_q      <= pc_d;
      if (fetch_w) begin
        ir_q <= bus.mem_rdata;
        if (instr_count_q != CNT_MAX)
          instr_count_q <= instr_count_q + 32'd1;
        // The HALT fetch itself loads IR, counts and lets its PC update land.
        if (bus.mem_rdata[31:26] == HALT_OPCODE)
          state_q <= ST_HALTED;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.mdr         = mdr_q;
  assign bus.reg_a       = a_q;
  assign bus.reg_b       = b_q;
  assign bus.alu_out     = alu_out_q;
  assign bus.opcode      = ir_q[31:26];
  assign bus.rs          = ir_q[25:21];
  assign bus.rt          = ir_q[20:16];
  assign bus.rd          = ir_q[15:11];
  assign bus.funct       = ir_q[5:0];
  assign bus.imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign bus.jump_target = jump_target_w;
  assign bus.pc_en       = pc_en_w;
  assign bus.halted      = halted_w;
  assign bus.instr_count = instr_count_q;

endmodule

`default_nettype wire
